// File: rtl/mem_arbiter_if.sv
// Request, grant and read-return signals for both requesters,
// plus the data RAM drive, bundled for the memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Core/host arbiter for the single-port data RAM, core priority with
// starvation forcing. Optional ARB_STATS_EN adds conflict/force counters.
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          start,
  mem_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt,
  output logic [7:0]    force_cnt
`endif
);

  typedef enum logic [1:0] {
    RS_NONE,
    RS_CORE,
    RS_HOST
  } rsel_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  rsel_t             rsel_q, rsel_d;
  logic [3:0]        wait_q, wait_d;
  logic              force_host;
  logic              host_gnt, core_gnt;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] core_rdata_q, host_rdata_q;

  always_comb begin
    force_host = (wait_q >= MAX_W);
    host_gnt   = 1'b0;
    core_gnt   = 1'b0;
    m_addr     = '0;
    m_we       = 1'b0;
    m_wdata    = '0;
    rsel_d     = RS_NONE;
    wait_d     = '0;

    if (!start) begin
      host_gnt = bus.host_req &
                 (~bus.core_req | force_host);
      core_gnt = bus.core_req & ~host_gnt;
    end

    unique case (1'b1)
      host_gnt: begin
        m_addr  = bus.host_addr;
        m_we    = bus.host_we;
        m_wdata = bus.host_wdata;
        if (!bus.host_we) rsel_d = RS_HOST;
      end
      core_gnt: begin
        m_addr  = bus.core_addr;
        m_we    = bus.core_we;
        m_wdata = bus.core_wdata;
        if (!bus.core_we) rsel_d = RS_CORE;
      end
      default: ;
    endcase

    // Saturate so force_host stays asserted until the host is served
    if (bus.host_req && !host_gnt)
      wait_d = (wait_q < MAX_W) ? wait_q + 4'd1 : wait_q;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rsel_q       <= RS_NONE;
      wait_q       <= '0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      rsel_q <= rsel_d;
      wait_q <= wait_d;
      if (rsel_d == RS_CORE) core_rdata_q <= bus.mem_rdata;
      if (rsel_d == RS_HOST) host_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (start) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (bus.core_req && bus.host_req &&
          conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
      if (host_gnt && force_host && force_cnt != 8'hFF)
        force_cnt <= force_cnt + 8'd1;
    end
  end
`endif

  assign bus.core_gnt    = core_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.mem_addr    = m_addr;
  assign bus.mem_we      = m_we;
  assign bus.mem_wdata   = m_wdata;
  assign bus.core_rvalid = (rsel_q == RS_CORE);
  assign bus.host_rvalid = (rsel_q == RS_HOST);
  assign bus.core_rdata  = core_rdata_q;
  assign bus.host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural data RAM.
// Expected values are hand-derived from the arbitration rules.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk;
  logic start;
  int   n_chk;
  int   n_fail;

  logic [DW-1:0] ram [256];

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [7:0]  force_cnt;
`endif

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .start(start),
    .bus(bus)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt(conflict_cnt),
    .force_cnt(force_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

  assign bus.mem_rdata = ram[bus.mem_addr];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    start  = 1'b1;
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_addr  = 8'h55;
    bus.core_wdata = 8'hAA;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;

    tick();
    tick();
    check("rst_core_gnt", bus.core_gnt, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_core_rvalid", bus.core_rvalid, 0);
    check("rst_host_rdata", bus.host_rdata, 0);

    bus.core_req = 1'b0;
    start = 1'b0;
    #1;
    check("idle_core_gnt", bus.core_gnt, 0);
    check("idle_host_gnt", bus.host_gnt, 0);
    check("idle_mem_we", bus.mem_we, 0);
    check("idle_mem_addr", bus.mem_addr, 0);
    tick();
    check("idle_core_rvalid", bus.core_rvalid, 0);
    check("idle_host_rvalid", bus.host_rvalid, 0);
    check("idle_core_rdata", bus.core_rdata, 0);

    // Host write then read back
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 8'h10;
    bus.host_wdata = 8'h5A;
    #1;
    check("hw_gnt", bus.host_gnt, 1);
    check("hw_mem_we", bus.mem_we, 1);
    check("hw_mem_addr", bus.mem_addr, 8'h10);
    check("hw_mem_wdata", bus.mem_wdata, 8'h5A);
    tick();
    check("hw_no_rvalid", bus.host_rvalid, 0);
    bus.host_we = 1'b0;
    #1;
    check("hr_gnt", bus.host_gnt, 1);
    check("hr_mem_we", bus.mem_we, 0);
    tick();
    bus.host_req = 1'b0;
    check("hr_rvalid", bus.host_rvalid, 1);
    check("hr_rdata", bus.host_rdata, 8'h5A);
    check("hr_core_rvalid", bus.core_rvalid, 0);
    tick();
    check("hr_pulse", bus.host_rvalid, 0);

    // Preload 0x77 at 0x03 through the host port
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 8'h03;
    bus.host_wdata = 8'h77;
    tick();
    bus.host_req = 1'b0;
    bus.host_we  = 1'b0;

    // Core read, host idle
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 8'h03;
    #1;
    check("cr_gnt", bus.core_gnt, 1);
    check("cr_mem_addr", bus.mem_addr, 8'h03);
    tick();
    bus.core_req = 1'b0;
    check("cr_rvalid", bus.core_rvalid, 1);
    check("cr_rdata", bus.core_rdata, 8'h77);
    check("cr_host_rdata", bus.host_rdata, 8'h5A);
    check("cr_host_rvalid", bus.host_rvalid, 0);

    // Core write then same-address read next cycle
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_addr  = 8'h20;
    bus.core_wdata = 8'h33;
    tick();
    bus.core_we = 1'b0;
    #1;
    check("raw_gnt", bus.core_gnt, 1);
    tick();
    bus.core_req = 1'b0;
    check("raw_rvalid", bus.core_rvalid, 1);
    check("raw_rdata", bus.core_rdata, 8'h33);
    tick();

    // Continuous dual reads: period-5 pattern
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.core_req  = 1'b1;
    bus.core_we   = 1'b0;
    bus.core_addr = 8'h03;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'h10;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("dual_cgnt%0d", k),
            bus.core_gnt, (k % 5) != 4);
      check($sformatf("dual_hgnt%0d", k),
            bus.host_gnt, (k % 5) == 4);
      tick();
      check($sformatf("dual_crv%0d", k),
            bus.core_rvalid, (k % 5) != 4);
      check($sformatf("dual_hrv%0d", k),
            bus.host_rvalid, (k % 5) == 4);
    end
    check("dual_core_rdata", bus.core_rdata, 8'h77);
    check("dual_host_rdata", bus.host_rdata, 8'h5A);
`ifdef ARB_STATS_EN
    check("stat_conflict", conflict_cnt, 10);
    check("stat_force", force_cnt, 2);
`endif
    bus.core_req = 1'b0;
    bus.host_req = 1'b0;
    tick();

    // Reset lands on the edge that would return host data
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'h10;
    #1;
    check("mr_gnt", bus.host_gnt, 1);
    start = 1'b1;
    #1;
    check("mr_gnt_rst", bus.host_gnt, 0);
    tick();
    bus.host_req = 1'b0;
    check("mr_host_rvalid", bus.host_rvalid, 0);
    check("mr_host_rdata", bus.host_rdata, 0);
    check("mr_core_rdata", bus.core_rdata, 0);
    tick();
    start = 1'b0;
    tick();
    check("mr_host_rvalid2", bus.host_rvalid, 0);
    check("mr_core_rvalid2", bus.core_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
